// File: rtl/ecg_sample_sequencer.sv
// ecg_sample_sequencer: derives a sample tick from bigClk with a programmable
// divider and, per tick, runs one ch_req/ch_ack handshake per lead, round-robin.
// Ports: bigClk, rst (async, active high); start/stop control; div_load/div_value
//   reprogram the divide ratio; ch_ack from the ADC; busy, tick, ch_req, ch_sel,
//   frame_done, overrun (sticky) and timeout_err (sticky) are registered outputs.
// Optional build macro ECG_SEQ_TIMEOUT_EN adds a per-lead ack timeout of
//   TIMEOUT_CYC cycles; without it REQ waits for ack indefinitely.
module ecg_sample_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      bigClk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      div_load,
  input  logic [DIV_W-1:0]          div_value,
  input  logic                      ch_ack,
  output logic                      busy,
  output logic                      tick,
  output logic                      ch_req,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      frame_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int SW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, WAIT, REQ, NEXT} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    sel_nxt;
  logic             fd_nxt;
  logic             start_acc;
  logic             last_lead;
  logic             to_hit;

  logic [DIV_W-1:0] div_reg, div_nxt;
  logic [DIV_W-1:0] pend_val, pend_val_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] load_val;
  logic             wrap;
  logic             tick_nxt;

  assign start_acc = (state == IDLE) && start && !stop;
  assign last_lead = (ch_sel == SW'(NUM_CH - 1));

  // Ratios below 2 would make the tick permanently high.
  assign load_val = (div_value < DIV_W'(2)) ? DIV_W'(2) : div_value;
  assign wrap     = (state != IDLE) && (cnt == div_reg - DIV_W'(1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge bigClk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch_sel     <= '0;
      busy       <= 1'b0;
      ch_req     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch_sel     <= sel_nxt;
      busy       <= (state_nxt != IDLE);
      ch_req     <= (state_nxt == REQ);
      frame_done <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = ch_sel;
    fd_nxt    = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = '0;
        if (start) state_nxt = WAIT;
      end
      WAIT: begin
        if (tick) state_nxt = REQ;
      end
      REQ: begin
        // frame_done is registered, so it is raised on the way into the
        // last lead's NEXT cycle.
        if (ch_ack || to_hit) begin
          state_nxt = NEXT;
          fd_nxt    = last_lead;
        end
      end
      NEXT: begin
        if (last_lead) begin
          sel_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          sel_nxt   = ch_sel + SW'(1);
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // stop overrides everything, including a simultaneous start.
    if (stop) begin
      state_nxt = IDLE;
      sel_nxt   = '0;
      fd_nxt    = 1'b0;
    end
  end

  // ------------------------------------------------------------ divider
  always_comb begin
    div_nxt      = div_reg;
    pend_val_nxt = pend_val;
    pend_vld_nxt = pend_vld;
    if (state == IDLE || wrap) begin
      // A fresh load beats an older pending value.
      if (div_load)      div_nxt = load_val;
      else if (pend_vld) div_nxt = pend_val;
      pend_vld_nxt = 1'b0;
    end else if (div_load) begin
      pend_val_nxt = load_val;
      pend_vld_nxt = 1'b1;
    end

    if (state == IDLE || state_nxt == IDLE || wrap) cnt_nxt = '0;
    else                                            cnt_nxt = cnt + DIV_W'(1);

    // Registered tick: predict the count of the next cycle against the ratio
    // that will be in force then.
    tick_nxt = (state_nxt != IDLE) && (cnt_nxt == div_nxt - DIV_W'(1));
  end

  always_ff @(posedge bigClk or posedge rst) begin
    if (rst) begin
      div_reg  <= DIV_W'(DEFAULT_DIV);
      pend_val <= '0;
      pend_vld <= 1'b0;
      cnt      <= '0;
      tick     <= 1'b0;
    end else begin
      div_reg  <= div_nxt;
      pend_val <= pend_val_nxt;
      pend_vld <= pend_vld_nxt;
      cnt      <= cnt_nxt;
      tick     <= tick_nxt;
    end
  end

  // ------------------------------------------------------------ overrun
  // A tick while a frame is still in flight is dropped; the frame completes.
  always_ff @(posedge bigClk or posedge rst) begin
    if (rst)                                       overrun <= 1'b0;
    else if (start_acc)                            overrun <= 1'b0;
    else if (tick && (state == REQ || state == NEXT)) overrun <= 1'b1;
  end

  // ------------------------------------------------------------ timeout
`ifdef ECG_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  // REQ is never entered twice in a row, so clearing outside REQ restarts the
  // count at 0 for every lead.
  assign to_hit = (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge bigClk or posedge rst) begin
    if (rst)               tcnt <= '0;
    else if (state == REQ) tcnt <= tcnt + TW'(1);
    else                   tcnt <= '0;
  end

  always_ff @(posedge bigClk or posedge rst) begin
    if (rst)                                        timeout_err <= 1'b0;
    else if (start_acc)                             timeout_err <= 1'b0;
    else if (state == REQ && !ch_ack && to_hit)     timeout_err <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  // TIMEOUT_CYC has no effect in this build; the flag is permanently clear.
  assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: doc/ecg_sample_sequencer.md
# ecg_sample_sequencer

Schedules ECG front-end sampling: an internal programmable divider derives a sample tick from the fast system clock. On each tick the block walks round-robin through NUM_CH leads, running one request/acknowledge handshake per lead with the ADC interface. It sits between the system clock and the ADC capture logic and replaces free-running divided clocks with a single-clock enable scheme.

## Interface
- NUM_CH, 3: leads sequenced per frame; legal range 2..8.
- DIV_W, 16: width of the divide ratio.
- DEFAULT_DIV, 3: divide ratio loaded at reset.
- TIMEOUT_CYC, 255: ack timeout in cycles; used only with ECG_SEQ_TIMEOUT_EN.
- bigClk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sampling; honoured only in IDLE.
- stop  in  1  abort to IDLE from any state.
- div_load  in  1  capture div_value.
- div_value  in  DIV_W  new divide ratio.
- ch_ack  in  1  ADC acknowledge for the current lead.
- busy  out  1  high in every state except IDLE.
- tick  out  1  one-cycle sample strobe.
- ch_req  out  1  ADC request.
- ch_sel  out  $clog2(NUM_CH)  lead index; valid while ch_req is high.
- frame_done  out  1  one-cycle pulse after the last lead is acknowledged.
- overrun  out  1  sticky: a tick arrived outside WAIT.
- timeout_err  out  1  sticky ack-timeout flag.

## Operation
- Reset values: every output is 0. div_reg = DEFAULT_DIV, divider count = 0, state = IDLE.
- Divider:
  - Counts 0..div_reg-1 only while busy.
  - tick = 1 in the cycle where count == div_reg-1; the count then wraps to 0.
  - Period is exactly div_reg cycles.
  - div_value < 2 is clamped to 2 on load.
- div_load:
  - Accepted in any state.
  - In IDLE it takes effect immediately.
  - While busy it is held pending and applied at the next wrap.
  - A second load before that wrap overwrites the pending value.
- States:
  - IDLE: start -> WAIT. Count is cleared and ch_sel = 0.
  - WAIT: tick -> REQ.
  - REQ: ch_req = 1. A sampled ch_ack -> NEXT.
  - NEXT: ch_req = 0. If ch_sel == NUM_CH-1: ch_sel <- 0, frame_done = 1, -> WAIT. Otherwise ch_sel <- ch_sel+1, -> REQ.
- Handshake:
  - ch_req rises only in REQ and stays high until ch_ack is sampled high.
  - ch_sel is stable while ch_req is high.
  - ch_ack outside REQ is ignored.
- stop:
  - From any busy state, the next state is IDLE and ch_req drops next cycle.
  - No frame_done is issued.
  - If stop and start are both high, stop wins.
- overrun:
  - Set when tick occurs in REQ or NEXT. That tick is discarded.
  - The current frame continues normally.
  - Cleared only by rst or by an accepted start.
- timeout_err: cleared by rst or an accepted start.
- Mid-operation rst: immediate return to reset values. The pending divide ratio is discarded.

## Timing
- tick, ch_req, ch_sel, frame_done and busy are registered outputs.
- start sampled at edge 0 -> busy = 1 from cycle 1. First tick arrives div_reg cycles after start is accepted.
- tick at cycle T -> ch_req high at T+1.
- ack sampled at cycle A -> ch_req low at A+1 (NEXT). Next lead's ch_req is high at A+2.
- With ch_ack tied high, a frame occupies 2·NUM_CH cycles after tick.
  - frame_done appears at T+2·NUM_CH.
  - The block is back in WAIT at T+2·NUM_CH+1.
  - Overrun-free operation with instant ack therefore requires div_reg >= 2·NUM_CH+1.

## Configuration
- Macro: ECG_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in REQ.
  - If ch_req has been high TIMEOUT_CYC cycles without ack, then ch_req drops, timeout_err is set and the state moves to NEXT, skipping that lead.
  - frame_done still pulses at the end of the frame.
- Without the macro:
  - No counter is built; REQ waits indefinitely.
  - timeout_err is tied to 0.

## Test plan
- Reset mid-frame: assert rst while ch_req = 1 -> all outputs 0 in the same cycle, and div_reg reads back as 3 through a tick period of 3 after the next start.
- div=10, NUM_CH=3, ack tied high, start at cycle 0 -> tick at cycle 10; ch_req high at 11, 13, 15 with ch_sel 0, 1, 2; frame_done at 16; next tick at 20; overrun stays 0.
- div=4, ack tied high -> the second tick lands in REQ/NEXT, overrun = 1 and stays 1 until the next start; frame_done still at T+6.
- Load div_value=1 in IDLE -> tick period 2. Load 8 while busy -> the old period completes, then period 8 from the next wrap.
- ch_ack delayed 5 cycles on lead 1 -> ch_req and ch_sel=1 hold for 6 cycles, and ch_req drops the cycle after ack. Assert stop during REQ -> IDLE next cycle, no frame_done.
- With ECG_SEQ_TIMEOUT_EN and TIMEOUT_CYC=8, ack never given on lead 2 -> ch_req drops after 8 cycles, timeout_err = 1, frame_done pulses. Without the macro, ch_req stays high indefinitely.
